// File: rtl/exec_alu_pkg.sv
// exec_alu_pkg: shared constants for the execute-stage ALU.
// Holds widths, one-hot class bit indices and instruction field slices.
package exec_alu_pkg;

    localparam int ONEHOT_W = 16;
    localparam int DATA_W   = 32;

    // Instruction-class bit positions in the decoder one-hot vector
    localparam int OH_ADDU = 0;
    localparam int OH_SUBU = 1;
    localparam int OH_ORI  = 2;
    localparam int OH_LW   = 3;
    localparam int OH_SW   = 4;
    localparam int OH_BEQ  = 5;
    localparam int OH_LUI  = 6;
    localparam int OH_JAL  = 7;
    localparam int OH_JR   = 8;
    localparam int OH_J    = 9;
    localparam int OH_ADD  = 10;
    localparam int OH_SUB  = 11;
    localparam int OH_AND  = 12;
    localparam int OH_OR   = 13;
    localparam int OH_SLT  = 14;
    localparam int OH_SLL  = 15;

    // Instruction field slices
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;

endpackage

// File: rtl/exec_alu_comb.sv
// exec_alu_comb: combinational result and signed-overflow calculator.
// Ports: i_a/i_b operands, i_instr word, i_onehot class, i_pc -> o_r, o_ovf.
module exec_alu_comb #(
    parameter int ONEHOT_W = exec_alu_pkg::ONEHOT_W,
    parameter int DATA_W   = exec_alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [DATA_W-1:0]   i_instr,
    input  logic [ONEHOT_W-1:0] i_onehot,
    input  logic [DATA_W-1:0]   i_pc,
    output logic [DATA_W-1:0]   o_r,
    output logic                o_ovf
);
    import exec_alu_pkg::*;

    logic [ONEHOT_W-1:0] w_first;
    logic [15:0]         w_imm;
    logic [4:0]          w_shamt;
    logic [DATA_W-1:0]   w_sext;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_slt;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic                w_unused;

    // Isolate the lowest set bit so multi-hot vectors resolve by priority
    assign w_first = i_onehot & (~i_onehot + ONEHOT_W'(1));

    assign w_imm   = i_instr[IMM_MSB:IMM_LSB];
    assign w_shamt = i_instr[SHAMT_MSB:SHAMT_LSB];
    assign w_sext  = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_slt   = $signed(i_a) < $signed(i_b);

    // Signed overflow: result sign disagrees with the operand signs
    assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    assign w_unused = ^i_instr[DATA_W-1:16];

    always_comb begin
        o_r   = '0;
        o_ovf = 1'b0;
        unique case (1'b1)
            w_first[OH_ADDU]: o_r = w_sum;
            w_first[OH_SUBU]: o_r = w_diff;
            w_first[OH_ORI]:  o_r = i_a | {{(DATA_W-16){1'b0}}, w_imm};
            w_first[OH_LW]:   o_r = i_a + w_sext;
            w_first[OH_SW]:   o_r = i_a + w_sext;
            w_first[OH_LUI]:  o_r = {w_imm, 16'h0000};
            w_first[OH_JAL]:  o_r = i_pc + DATA_W'(8);
            w_first[OH_ADD]: begin
                o_r   = w_sum;
                o_ovf = w_add_ovf;
            end
            w_first[OH_SUB]: begin
                o_r   = w_diff;
                o_ovf = w_sub_ovf;
            end
            w_first[OH_AND]:  o_r = i_a & i_b;
            w_first[OH_OR]:   o_r = i_a | i_b;
            w_first[OH_SLT]:  o_r = {{(DATA_W-1){1'b0}}, w_slt};
            w_first[OH_SLL]:  o_r = i_b << w_shamt;
            // beq, jr, j and an empty vector produce zero
            default: begin
                o_r   = '0;
                o_ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exec_alu.sv
// exec_alu: execute-stage ALU with enable-gated, async-reset result register.
// Ports: clk, reset, en, A, B, instr, onehot, pc -> C (result), ovf.
module exec_alu #(
    parameter int ONEHOT_W = exec_alu_pkg::ONEHOT_W,
    parameter int DATA_W   = exec_alu_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [DATA_W-1:0]   instr,
    input  logic [ONEHOT_W-1:0] onehot,
    input  logic [DATA_W-1:0]   pc,
    output logic [DATA_W-1:0]   C,
    output logic                ovf
);
    import exec_alu_pkg::*;

    logic [DATA_W-1:0] w_r;
    logic              w_ovf;
    logic [DATA_W-1:0] r_c;
    logic              r_ovf;

    exec_alu_comb #(
        .ONEHOT_W (ONEHOT_W),
        .DATA_W   (DATA_W)
    ) u_comb (
        .i_a      (A),
        .i_b      (B),
        .i_instr  (instr),
        .i_onehot (onehot),
        .i_pc     (pc),
        .o_r      (w_r),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c   <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_c   <= w_r;
            r_ovf <= w_ovf;
        end
    end

    assign C   = r_c;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed and randomized checks of exec_alu.
// Random phase compares against an arithmetic reference model.
module tb_exec_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] A, B, instr, pc;
    logic [15:0] onehot;
    wire  [31:0] C;
    wire         ovf;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_c;
    logic        exp_o;
    logic [32:0] m;

    always #5 clk = ~clk;

    exec_alu dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .A      (A),
        .B      (B),
        .instr  (instr),
        .onehot (onehot),
        .pc     (pc),
        .C      (C),
        .ovf    (ovf)
    );

    function automatic logic [15:0] oh(input int idx);
        logic [15:0] v;
        v = 16'd1 << idx;
        return v;
    endfunction

    // Reference: returns {ovf, result} from the class rules
    function automatic logic [32:0] model(input logic [15:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] ins,
                                          input logic [31:0] p);
        int k;
        logic [31:0] r;
        logic        v;
        logic [15:0] imm;
        int          sh;
        longint      s;
        k   = -1;
        for (int i = 15; i >= 0; i--)
            if (o[i]) k = i;
        imm = ins[15:0];
        sh  = int'(ins[10:6]);
        r   = 32'd0;
        v   = 1'b0;
        case (k)
            0, 10: r = a + b;
            1, 11: r = a - b;
            2:     r = a | {16'd0, imm};
            3, 4:  r = a + {{16{imm[15]}}, imm};
            6:     r = {imm, 16'd0};
            7:     r = p + 32'd8;
            12:    r = a & b;
            13:    r = a | b;
            14:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            15:    r = b << sh;
            default: r = 32'd0;
        endcase
        if (k == 10 || k == 11) begin
            if (k == 10)
                s = longint'($signed(a)) + longint'($signed(b));
            else
                s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {v, r};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] ec,
                         input logic eo);
        checks++;
        assert (C === ec) else begin
            errors++;
            $error("FAIL %s C got=%h exp=%h", tag, C, ec);
        end
        checks++;
        assert (ovf === eo) else begin
            errors++;
            $error("FAIL %s ovf got=%b exp=%b", tag, ovf, eo);
        end
    endtask

    task automatic apply(input logic [15:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] ins,
                         input logic [31:0] p);
        onehot = o;
        A      = a;
        B      = b;
        instr  = ins;
        pc     = p;
    endtask

    task automatic step(input string tag,
                        input logic [15:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ins,
                        input logic [31:0] p,
                        input logic [31:0] ec,
                        input logic eo);
        apply(o, a, b, ins, p);
        @(posedge clk);
        #1;
        check(tag, ec, eo);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        apply(16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #12;
        check("rst_init", 32'd0, 1'b0);
        reset = 1'b0;

        // Async reset mid-cycle
        step("load", oh(0), 32'h12345678, 32'd0, 32'd0, 32'd0,
             32'h12345678, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async", 32'd0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold", 32'd0, 1'b0);
        end
        reset = 1'b0;

        // Arithmetic
        step("addu_wrap", oh(0), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
             32'd0, 1'b0);
        step("add_ovf", oh(10), 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0,
             32'h80000000, 1'b1);
        step("sub_ovf", oh(11), 32'h80000000, 32'd1, 32'd0, 32'd0,
             32'h7FFFFFFF, 1'b1);
        step("subu", oh(1), 32'h80000000, 32'd1, 32'd0, 32'd0,
             32'h7FFFFFFF, 1'b0);

        // Immediates
        step("ori", oh(2), 32'h000000F0, 32'd0, 32'h00008001, 32'd0,
             32'h000080F1, 1'b0);
        step("lw", oh(3), 32'h00000100, 32'd0, 32'h0000FFFC, 32'd0,
             32'h000000FC, 1'b0);
        step("sw", oh(4), 32'h00000100, 32'd0, 32'h00000010, 32'd0,
             32'h00000110, 1'b0);
        step("lui", oh(6), 32'hDEADBEEF, 32'd0, 32'h0000ABCD, 32'd0,
             32'hABCD0000, 1'b0);

        // Logic, compare, shift
        step("slt_neg", oh(14), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
             32'd1, 1'b0);
        step("slt_eq", oh(14), 32'd5, 32'd5, 32'd0, 32'd0,
             32'd0, 1'b0);
        step("and", oh(12), 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'd0,
             32'h0000F000, 1'b0);
        step("or", oh(13), 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'd0,
             32'h0000FFF0, 1'b0);
        step("sll", oh(15), 32'd0, 32'h80000001, 32'h00000100, 32'd0,
             32'h00000010, 1'b0);

        // Link and no-op classes
        step("jal", oh(7), 32'd0, 32'd0, 32'd0, 32'h00003000,
             32'h00003008, 1'b0);
        step("beq", oh(5), 32'd7, 32'd9, 32'h1234, 32'h40,
             32'd0, 1'b0);
        step("jr", oh(8), 32'd7, 32'd9, 32'h1234, 32'h40,
             32'd0, 1'b0);
        step("none", 16'd0, 32'd7, 32'd9, 32'h1234, 32'h40,
             32'd0, 1'b0);
        step("prio", 16'h0003, 32'd3, 32'd1, 32'd0, 32'd0,
             32'd4, 1'b0);

        // Stall
        step("stall_ld", oh(0), 32'd3, 32'd4, 32'd0, 32'd0,
             32'd7, 1'b0);
        en = 1'b0;
        apply(oh(11), 32'd9, 32'd1, 32'd0, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_hold", 32'd7, 1'b0);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        check("stall_rel", 32'd8, 1'b0);

        // Randomized against the reference model
        exp_c = 32'd8;
        exp_o = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] o;
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0:       o = 16'd0;
                1:       o = oh(int'($urandom_range(0, 15)));
                default: o = 16'($urandom);
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) a = {~a[31], 31'h7FFFFFFF} ^ {1'b0, a[30:0]} ^ {1'b0, a[30:0]};
            if ($urandom_range(0, 4) == 0) b = 32'h80000000;
            apply(o, a, b, $urandom, $urandom);
            en = ($urandom_range(0, 3) != 0);
            m  = model(o, a, b, instr, pc);
            if (en) begin
                exp_c = m[31:0];
                exp_o = m[32];
            end
            @(posedge clk);
            #1;
            check("rand", exp_c, exp_o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
